// File: rtl/x1_vram_arb.sv
// ============================================================================
// x1_vram_arb : VRAM bank arbiter, Z80 I/O access vs. CRTC display fetch
// Revision    : 1.0
// ============================================================================
`default_nettype none

module x1_vram_arb #(
  parameter int CPU_MAXWAIT = 4
) (
  input  logic        I_CLK,
  input  logic        I_RESET_n,
  input  logic [5:0]  I_CS,
  input  logic        I_RD_n,
  input  logic        I_WR_n,
  input  logic [13:0] I_A,
  input  logic [7:0]  I_D,
  output logic [7:0]  O_D,
  output logic        O_WAIT_n,
  input  logic        I_VID_REQ,
  input  logic [13:0] I_VID_A,
  output logic        O_VID_ACK,
  output logic        O_VID_VALID,
  output logic [13:0] O_MEM_A,
  output logic [5:0]  O_MEM_CE,
  output logic [5:0]  O_MEM_WE,
  output logic [7:0]  O_MEM_D,
  input  logic [47:0] I_MEM_Q
);

  localparam logic [3:0] MAXWAIT = 4'(CPU_MAXWAIT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PEND  = 3'd1,
    S_ISSUE = 3'd2,
    S_DATA  = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  starve_q, starve_d;
  logic        act_q;
  logic [5:0]  planes_q;
  logic        wr_q;
  logic [13:0] a_q;
  logic [7:0]  d_q;
  logic [7:0]  dout_q;
  logic        valid_q;

  logic        act_w, start_w, cpu_pend_w, vid_gnt_w;
  logic [7:0]  rdata_w;

  assign act_w   = (|I_CS) & ~(I_RD_n & I_WR_n);
  assign start_w = act_w & ~act_q & (state_q == S_IDLE);

  assign cpu_pend_w = start_w | ((state_q == S_PEND) & (|I_CS));
  assign vid_gnt_w  = I_RESET_n & I_VID_REQ & (state_q != S_ISSUE) &
                      (~cpu_pend_w | (starve_q < MAXWAIT));

  assign O_WAIT_n    = ~(cpu_pend_w | (state_q == S_ISSUE) | (state_q == S_DATA));
  assign O_VID_ACK   = vid_gnt_w;
  assign O_VID_VALID = valid_q;
  assign O_D         = dout_q;

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    case (state_q)
      S_IDLE: begin
        if (start_w) begin
          if (vid_gnt_w) begin
            state_d  = S_PEND;
            starve_d = starve_q + 4'd1;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_PEND: begin
        if (~|I_CS) begin
          state_d  = S_IDLE;
          starve_d = 4'd0;
        end else if (vid_gnt_w) begin
          starve_d = starve_q + 4'd1;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_DATA;
      S_DATA: begin
        state_d  = S_HOLD;
        starve_d = 4'd0;
      end
      S_HOLD: begin
        if ((I_RD_n & I_WR_n) | ~|I_CS) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    O_MEM_CE = 6'h00;
    O_MEM_WE = 6'h00;
    O_MEM_A  = 14'h0000;
    O_MEM_D  = 8'h00;
    if (state_q == S_ISSUE) begin
      O_MEM_CE = planes_q;
      O_MEM_WE = wr_q ? planes_q : 6'h00;
      // Character planes are 2K deep; only graphic planes see the full address.
      O_MEM_A  = (|planes_q[2:0]) ? a_q : {3'b000, a_q[10:0]};
      O_MEM_D  = wr_q ? d_q : 8'h00;
    end else if (vid_gnt_w) begin
      O_MEM_CE = 6'h3F;
      O_MEM_A  = I_VID_A;
    end
  end

  // Descending scan so the lowest selected plane wins.
  always_comb begin
    rdata_w = 8'h00;
    for (int i = 5; i >= 0; i--) begin
      if (planes_q[i]) rdata_w = I_MEM_Q[8*i +: 8];
    end
  end

  always_ff @(posedge I_CLK or negedge I_RESET_n) begin
    if (!I_RESET_n) begin
      state_q  <= S_IDLE;
      starve_q <= 4'd0;
      // Held set so a strobe still active across reset is not replayed.
      act_q    <= 1'b1;
      planes_q <= 6'h00;
      wr_q     <= 1'b0;
      a_q      <= 14'h0000;
      d_q      <= 8'h00;
      dout_q   <= 8'h00;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      act_q    <= act_w;
      valid_q  <= vid_gnt_w;
      if (start_w) begin
        planes_q <= I_CS;
        wr_q     <= ~I_WR_n;
        a_q      <= I_A;
        d_q      <= I_D;
      end
      if ((state_q == S_DATA) && !wr_q) dout_q <= rdata_w;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_x1_vram_arb.sv
// ============================================================================
// tb_x1_vram_arb : directed self-checking bench for x1_vram_arb
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_x1_vram_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  cs;
  logic        rd_n, wr_n;
  logic [13:0] a;
  logic [7:0]  d;
  logic [7:0]  o_d;
  logic        wait_n;
  logic        vid_req;
  logic [13:0] vid_a;
  logic        vid_ack, vid_valid;
  logic [13:0] mem_a;
  logic [5:0]  mem_ce, mem_we;
  logic [7:0]  mem_d;
  logic [47:0] mem_q;

  int tests = 0;
  int fails = 0;

  x1_vram_arb #(.CPU_MAXWAIT(4)) dut (
    .I_CLK(clk), .I_RESET_n(rst_n), .I_CS(cs), .I_RD_n(rd_n), .I_WR_n(wr_n),
    .I_A(a), .I_D(d), .O_D(o_d), .O_WAIT_n(wait_n),
    .I_VID_REQ(vid_req), .I_VID_A(vid_a), .O_VID_ACK(vid_ack), .O_VID_VALID(vid_valid),
    .O_MEM_A(mem_a), .O_MEM_CE(mem_ce), .O_MEM_WE(mem_we), .O_MEM_D(mem_d),
    .I_MEM_Q(mem_q)
  );

  always #5 clk = ~clk;

  task automatic bus_idle();
    cs = 6'h00; rd_n = 1'b1; wr_n = 1'b1; a = 14'h0; d = 8'h00;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus_idle(); vid_req = 1'b1; vid_a = 14'h1234; mem_q = 48'h0;
    #12;
    tests++; if (wait_n !== 1'b1)   begin fails++; $display("FAIL reset_wait got=%b exp=1", wait_n); end
    tests++; if (vid_ack !== 1'b0)  begin fails++; $display("FAIL reset_ack got=%b exp=0", vid_ack); end
    tests++; if (vid_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", vid_valid); end
    tests++; if (mem_ce !== 6'h00)  begin fails++; $display("FAIL reset_ce got=%h exp=00", mem_ce); end
    tests++; if (mem_we !== 6'h00)  begin fails++; $display("FAIL reset_we got=%h exp=00", mem_we); end
    tests++; if (o_d !== 8'h00)     begin fails++; $display("FAIL reset_od got=%h exp=00", o_d); end
    tests++; if (mem_a !== 14'h0)   begin fails++; $display("FAIL reset_mema got=%h exp=0000", mem_a); end
    tests++; if (mem_d !== 8'h00)   begin fails++; $display("FAIL reset_memd got=%h exp=00", mem_d); end
    vid_req = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_cpu_write();
    int wl = 0, wec = 0;
    logic [5:0] cwe = '0; logic [13:0] ca = '0; logic [7:0] cd = '0;
    @(negedge clk); cs = 6'h02; wr_n = 1'b0; a = 14'h0123; d = 8'h5A;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) begin @(negedge clk); if (c == 3) bus_idle(); end
      #1;
      if (!wait_n) wl++;
      if (mem_we != 6'h00) begin wec++; cwe = mem_we; ca = mem_a; cd = mem_d; end
    end
    tests++; if (wl != 3)        begin fails++; $display("FAIL wr_wait_cycles got=%0d exp=3", wl); end
    tests++; if (wec != 1)       begin fails++; $display("FAIL wr_we_cycles got=%0d exp=1", wec); end
    tests++; if (cwe !== 6'h02)  begin fails++; $display("FAIL wr_we got=%h exp=02", cwe); end
    tests++; if (ca !== 14'h0123) begin fails++; $display("FAIL wr_addr got=%h exp=0123", ca); end
    tests++; if (cd !== 8'h5A)   begin fails++; $display("FAIL wr_data got=%h exp=5a", cd); end
  endtask

  task automatic test_cpu_read();
    int wl = 0, wec = 0;
    logic [5:0] cce = '0; logic [13:0] ca = '0;
    mem_q = 48'h1122_C344_5566;
    @(negedge clk); cs = 6'h08; rd_n = 1'b0; a = 14'h07FF;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) begin @(negedge clk); if (c == 3) bus_idle(); end
      #1;
      if (!wait_n) wl++;
      if (mem_we != 6'h00) wec++;
      if (mem_ce != 6'h00) begin cce = mem_ce; ca = mem_a; end
    end
    tests++; if (wl != 3)         begin fails++; $display("FAIL rd_wait_cycles got=%0d exp=3", wl); end
    tests++; if (o_d !== 8'hC3)   begin fails++; $display("FAIL rd_data got=%h exp=c3", o_d); end
    tests++; if (cce !== 6'h08)   begin fails++; $display("FAIL rd_ce got=%h exp=08", cce); end
    tests++; if (ca !== 14'h07FF) begin fails++; $display("FAIL rd_addr got=%h exp=07ff", ca); end
    tests++; if (wec != 0)        begin fails++; $display("FAIL rd_we_cycles got=%0d exp=0", wec); end
  endtask

  task automatic test_starvation();
    logic ack_h [10]; logic val_h [10]; logic [5:0] ce_h [10]; logic [13:0] a_h [10];
    int wl = 0, acks = 0;
    vid_a = 14'h1555;
    @(negedge clk); vid_req = 1'b1; cs = 6'h01; rd_n = 1'b0; a = 14'h0042;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) begin @(negedge clk); if (c == 7) bus_idle(); end
      #1;
      ack_h[c] = vid_ack; val_h[c] = vid_valid; ce_h[c] = mem_ce; a_h[c] = mem_a;
      if (!wait_n) wl++;
      if (c < 5 && vid_ack) acks++;
    end
    vid_req = 1'b0;
    tests++; if (acks != 4)          begin fails++; $display("FAIL starve_acks got=%0d exp=4", acks); end
    tests++; if (ack_h[4] !== 1'b0)  begin fails++; $display("FAIL starve_gap_ack got=%b exp=0", ack_h[4]); end
    tests++; if (ce_h[5] !== 6'h01 || ack_h[5] !== 1'b0)
      begin fails++; $display("FAIL starve_issue_ce got=%h/%b exp=01/0", ce_h[5], ack_h[5]); end
    tests++; if (a_h[5] !== 14'h0042) begin fails++; $display("FAIL starve_issue_addr got=%h exp=0042", a_h[5]); end
    tests++; if (ack_h[6] !== 1'b1 || ce_h[6] !== 6'h3F)
      begin fails++; $display("FAIL starve_resume got=%b/%h exp=1/3f", ack_h[6], ce_h[6]); end
    tests++; if (a_h[0] !== 14'h1555) begin fails++; $display("FAIL starve_vid_addr got=%h exp=1555", a_h[0]); end
    tests++; if (val_h[1] !== 1'b1 || val_h[6] !== 1'b0)
      begin fails++; $display("FAIL starve_valid got=%b%b exp=10", val_h[1], val_h[6]); end
    tests++; if (wl != 7)            begin fails++; $display("FAIL starve_wait_cycles got=%0d exp=7", wl); end
    tests++; if (o_d !== 8'h66)      begin fails++; $display("FAIL starve_rd_data got=%h exp=66", o_d); end
  endtask

  task automatic test_dam_write();
    int wec = 0;
    logic [5:0] cwe = '0, cce = '0; logic [13:0] ca = '0; logic [7:0] cd = '0;
    @(negedge clk); cs = 6'h07; wr_n = 1'b0; a = 14'h2ABC; d = 8'hFF;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) begin @(negedge clk); if (c == 3) bus_idle(); end
      #1;
      if (mem_we != 6'h00) begin wec++; cwe = mem_we; cce = mem_ce; ca = mem_a; cd = mem_d; end
    end
    tests++; if (wec != 1)        begin fails++; $display("FAIL dam_we_cycles got=%0d exp=1", wec); end
    tests++; if (cwe !== 6'h07 || cce !== 6'h07)
      begin fails++; $display("FAIL dam_we_ce got=%h/%h exp=07/07", cwe, cce); end
    tests++; if (ca !== 14'h2ABC) begin fails++; $display("FAIL dam_addr got=%h exp=2abc", ca); end
    tests++; if (cd !== 8'hFF)    begin fails++; $display("FAIL dam_data got=%h exp=ff", cd); end
  endtask

  task automatic test_simultaneous();
    vid_a = 14'h0321;
    @(negedge clk); vid_req = 1'b1; cs = 6'h10; wr_n = 1'b0; a = 14'h3FFF; d = 8'hA5;
    #1;
    tests++; if (vid_ack !== 1'b1 || wait_n !== 1'b0 || mem_we !== 6'h00)
      begin fails++; $display("FAIL simul_c0 ack/wait/we got=%b/%b/%h exp=1/0/00", vid_ack, wait_n, mem_we); end
    @(negedge clk); vid_req = 1'b0; #1;
    tests++; if (vid_ack !== 1'b0 || mem_ce !== 6'h00)
      begin fails++; $display("FAIL simul_c1 ack/ce got=%b/%h exp=0/00", vid_ack, mem_ce); end
    @(negedge clk); #1;
    tests++; if (mem_ce !== 6'h10 || mem_we !== 6'h10)
      begin fails++; $display("FAIL simul_issue ce/we got=%h/%h exp=10/10", mem_ce, mem_we); end
    tests++; if (mem_a !== 14'h07FF || mem_d !== 8'hA5)
      begin fails++; $display("FAIL simul_issue addr/data got=%h/%h exp=07ff/a5", mem_a, mem_d); end
    @(negedge clk); #1;
    tests++; if (wait_n !== 1'b0) begin fails++; $display("FAIL simul_data_wait got=%b exp=0", wait_n); end
    @(negedge clk); bus_idle(); #1;
    tests++; if (wait_n !== 1'b1) begin fails++; $display("FAIL simul_hold_wait got=%b exp=1", wait_n); end
  endtask

  task automatic test_reset_in_pend();
    int bad = 0;
    @(negedge clk); vid_req = 1'b1; cs = 6'h02; wr_n = 1'b0; a = 14'h0010; d = 8'h77;
    #1;
    tests++; if (vid_ack !== 1'b1) begin fails++; $display("FAIL rstp_c0_ack got=%b exp=1", vid_ack); end
    @(negedge clk); #1;
    rst_n = 1'b0; vid_req = 1'b0; #1;
    tests++; if (wait_n !== 1'b1 || mem_ce !== 6'h00 || mem_we !== 6'h00)
      begin fails++; $display("FAIL rstp_abort wait/ce/we got=%b/%h/%h exp=1/00/00", wait_n, mem_ce, mem_we); end
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      if (mem_we != 6'h00 || wait_n !== 1'b1) bad++;
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL rstp_no_retry got=%0d bad cycles exp=0", bad); end
    @(negedge clk); bus_idle();
  endtask

  task automatic test_abort_pend();
    int bad = 0;
    @(negedge clk); vid_req = 1'b1; cs = 6'h04; rd_n = 1'b0; a = 14'h0005;
    #1;
    tests++; if (vid_ack !== 1'b1 || wait_n !== 1'b0)
      begin fails++; $display("FAIL abort_c0 ack/wait got=%b/%b exp=1/0", vid_ack, wait_n); end
    @(negedge clk); cs = 6'h00; vid_req = 1'b0; #1;
    tests++; if (wait_n !== 1'b1 || mem_ce !== 6'h00)
      begin fails++; $display("FAIL abort_c1 wait/ce got=%b/%h exp=1/00", wait_n, mem_ce); end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      if (mem_ce != 6'h00 || wait_n !== 1'b1) bad++;
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL abort_no_access got=%0d bad cycles exp=0", bad); end
    bus_idle();
  endtask

  task automatic test_back_to_back();
    vid_a = 14'h0AAA;
    @(negedge clk); vid_req = 1'b1; #1;
    tests++; if (vid_ack !== 1'b1 || mem_ce !== 6'h3F || mem_we !== 6'h00 || mem_a !== 14'h0AAA)
      begin fails++; $display("FAIL b2b_c0 ack/ce/we/a got=%b/%h/%h/%h exp=1/3f/00/0aaa", vid_ack, mem_ce, mem_we, mem_a); end
    @(negedge clk); #1;
    tests++; if (vid_ack !== 1'b1 || vid_valid !== 1'b1)
      begin fails++; $display("FAIL b2b_c1 ack/valid got=%b/%b exp=1/1", vid_ack, vid_valid); end
    @(negedge clk); vid_req = 1'b0; #1;
    tests++; if (vid_ack !== 1'b0 || vid_valid !== 1'b1)
      begin fails++; $display("FAIL b2b_c2 ack/valid got=%b/%b exp=0/1", vid_ack, vid_valid); end
    @(negedge clk); #1;
    tests++; if (vid_valid !== 1'b0) begin fails++; $display("FAIL b2b_c3 valid got=%b exp=0", vid_valid); end
  endtask

  initial begin
    test_reset();
    test_cpu_write();
    test_cpu_read();
    test_starvation();
    test_dam_write();
    test_simultaneous();
    test_reset_in_pend();
    test_abort_pend();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
